// File: rtl/ram_copy_master_pkg.sv
// Shared types and width defaults for the RAM block-copy master.
package ram_copy_master_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, FINISH} copy_state_t;

endpackage

// File: rtl/ram_copy_master_if.sv
// RAM bus between the copy master (initiator) and the ucontroller RAM (target).
interface ram_copy_master_if
  import ram_copy_master_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);
  logic              Cs;
  logic              Wen;
  logic              Oen;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataOut;
  logic [DATA_W-1:0] DataIn;

  modport master (output Cs, Wen, Oen, Address, DataOut, input DataIn);
  modport slave  (input Cs, Wen, Oen, Address, DataOut, output DataIn);
endinterface

// File: rtl/ram_copy_master.sv
// Byte-wise forward block copy inside RAM: READ, WAIT (READ_LATENCY), WRITE per byte.
// Optional running byte checksum when RAM_COPY_MASTER_CHECKSUM_EN is defined.
module ram_copy_master
  import ram_copy_master_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = RAM_ADDR_W,
  parameter int DATA_W       = RAM_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  output logic              Busy,
  output logic              Done,
  ram_copy_master_if.master ram
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] Checksum
`endif
);

  localparam int LAT_W = 2;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  copy_state_t       state_q, state_nxt;
  logic [ADDR_W-1:0] src_q, src_nxt, dst_q, dst_nxt, rem_q, rem_nxt;
  logic [LAT_W-1:0]  lat_q, lat_nxt;
  logic              busy_q, busy_nxt, done_q, done_nxt;
  logic              cs_q, cs_nxt, wen_q, wen_nxt, oen_q, oen_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] dout_q, dout_nxt;
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_nxt;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cs_q    <= 1'b0;
      wen_q   <= 1'b0;
      oen_q   <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      src_q   <= src_nxt;
      dst_q   <= dst_nxt;
      rem_q   <= rem_nxt;
      lat_q   <= lat_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      cs_q    <= cs_nxt;
      wen_q   <= wen_nxt;
      oen_q   <= oen_nxt;
      addr_q  <= addr_nxt;
      dout_q  <= dout_nxt;
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
      sum_q   <= sum_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    rem_nxt   = rem_q;
    lat_nxt   = lat_q;
    dout_nxt  = dout_q;
    addr_nxt  = addr_q;
    unique case (state_q)
      IDLE: if (Start) begin
        src_nxt   = SrcAddr;
        dst_nxt   = DstAddr;
        rem_nxt   = Len;
        state_nxt = (Len == '0) ? FINISH : READ;
      end
      READ: begin
        lat_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: if (lat_q == LAT_LAST) begin
        // DataOut doubles as the byte buffer so the write can issue next cycle
        dout_nxt  = ram.DataIn;
        state_nxt = WRITE;
      end else begin
        lat_nxt = lat_q + 1'b1;
      end
      WRITE: begin
        src_nxt   = src_q + 1'b1;
        dst_nxt   = dst_q + 1'b1;
        rem_nxt   = rem_q - 1'b1;
        state_nxt = (rem_q == ADDR_W'(1)) ? FINISH : READ;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Bus outputs are registered, so they are decoded from the next state
    cs_nxt   = (state_nxt == READ) || (state_nxt == WRITE);
    oen_nxt  = (state_nxt == READ);
    wen_nxt  = (state_nxt == WRITE);
    busy_nxt = (state_nxt == READ) || (state_nxt == WAIT) || (state_nxt == WRITE);
    done_nxt = (state_nxt == FINISH);
    if (state_nxt == READ)  addr_nxt = src_nxt;
    if (state_nxt == WRITE) addr_nxt = dst_q;
  end

`ifdef RAM_COPY_MASTER_CHECKSUM_EN
  always_comb begin
    sum_nxt = sum_q;
    if (state_q == IDLE && Start) sum_nxt = '0;
    else if (state_q == WRITE)    sum_nxt = sum_q + dout_q;
  end
  assign Checksum = sum_q;
`endif

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign ram.Cs      = cs_q;
  assign ram.Wen     = wen_q;
  assign ram.Oen     = oen_q;
  assign ram.Address = addr_q;
  assign ram.DataOut = dout_q;

endmodule

// File: tb/tb_ram_copy_master.sv
// Directed bench: READ_LATENCY=1 and READ_LATENCY=3 copy masters, each on its own RAM model.
module tb_ram_copy_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, start3 = 1'b0;
  logic [7:0] src = '0, dst = '0, len = '0;
  logic       busy1, done1, busy3, done3;
  logic       pre_we1 = 1'b0, pre_we3 = 1'b0;
  logic [7:0] pre_a = '0, pre_d = '0;
  int         n_chk = 0, n_fail = 0;
  int         viol = 0, cs1_cyc = 0, busy1_cyc = 0;
  logic [7:0] rlog[$], wlog_a[$], wlog_d[$];
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] rd1;
  logic [7:0] rp3 [3];
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
  logic [7:0] csum1, csum3;
`endif

  always #5 clk = ~clk;

  ram_copy_master_if r1 ();
  ram_copy_master_if r3 ();

  ram_copy_master #(.READ_LATENCY(1)) dut (
    .Clk(clk), .Rst(rst), .Start(start), .SrcAddr(src), .DstAddr(dst), .Len(len),
    .Busy(busy1), .Done(done1), .ram(r1)
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
    , .Checksum(csum1)
`endif
  );

  ram_copy_master #(.READ_LATENCY(3)) dut3 (
    .Clk(clk), .Rst(rst), .Start(start3), .SrcAddr(src), .DstAddr(dst), .Len(len),
    .Busy(busy3), .Done(done3), .ram(r3)
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
    , .Checksum(csum3)
`endif
  );

  // RAM models: read data appears READ_LATENCY cycles after the request cycle
  always @(posedge clk) begin
    if (pre_we1) mem1[pre_a] <= pre_d;
    if (r1.Cs && r1.Wen) mem1[r1.Address] <= r1.DataOut;
    rd1 <= mem1[r1.Address];
    if (pre_we3) mem3[pre_a] <= pre_d;
    if (r3.Cs && r3.Wen) mem3[r3.Address] <= r3.DataOut;
    rp3[0] <= mem3[r3.Address];
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign r1.DataIn = rd1;
  assign r3.DataIn = rp3[2];

  // Protocol monitor and bus logs (values of the cycle just ended)
  always @(posedge clk) begin
    if ((r1.Wen && r1.Oen) || (r1.Cs != (r1.Wen || r1.Oen))) viol++;
    if ((r3.Wen && r3.Oen) || (r3.Cs != (r3.Wen || r3.Oen))) viol++;
    if (r1.Cs) cs1_cyc++;
    if (busy1) busy1_cyc++;
    if (r1.Cs && r1.Oen) rlog.push_back(r1.Address);
    if (r1.Cs && r1.Wen) begin
      wlog_a.push_back(r1.Address);
      wlog_d.push_back(r1.DataOut);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic preload(input bit use3, input logic [7:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d;
    if (use3) pre_we3 = 1'b1; else pre_we1 = 1'b1;
    @(negedge clk);
    pre_we1 = 1'b0; pre_we3 = 1'b0;
  endtask

  // Called at a negedge; returns cycles from the Start cycle to the Done cycle
  task automatic run(input bit use3, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] l, output int cyc);
    src = s; dst = d; len = l;
    if (use3) start3 = 1'b1; else start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0; start3 = 1'b0;
    end while (!(use3 ? done3 : done1) && cyc < 1000);
    @(negedge clk);
    check("done_pulse", use3 ? done3 : done1, 0);
  endtask

  initial begin
    int cyc, w0, r0, c0, b0, nd;
    #12;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_cs",   r1.Cs, 0);
    check("rst_wen",  r1.Wen, 0);
    check("rst_oen",  r1.Oen, 0);
    check("rst_addr", r1.Address, 0);
    check("rst_dout", r1.DataOut, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic copy of four bytes
    preload(0, 8'h40, 8'h11); preload(0, 8'h41, 8'h22);
    preload(0, 8'h42, 8'h33); preload(0, 8'h43, 8'h44);
    w0 = wlog_a.size(); c0 = cs1_cyc;
    run(0, 8'h40, 8'h80, 8'd4, cyc);
    check("copy4_cycles", cyc, 13);
    check("copy4_b0", mem1[8'h80], 8'h11);
    check("copy4_b1", mem1[8'h81], 8'h22);
    check("copy4_b2", mem1[8'h82], 8'h33);
    check("copy4_b3", mem1[8'h83], 8'h44);
    check("copy4_writes", wlog_a.size() - w0, 4);
    check("copy4_cs_cycles", cs1_cyc - c0, 8);
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
    check("copy4_checksum", csum1, 8'hAA);
`endif

    // Zero length: immediate Done, no bus activity
    c0 = cs1_cyc; b0 = busy1_cyc;
    run(0, 8'h10, 8'h90, 8'd0, cyc);
    check("len0_cycles", cyc, 1);
    check("len0_busy", busy1_cyc - b0, 0);
    check("len0_cs", cs1_cyc - c0, 0);

    // Address wrap on source
    preload(0, 8'hFE, 8'hA1); preload(0, 8'hFF, 8'hB2); preload(0, 8'h00, 8'hC3);
    r0 = rlog.size(); w0 = wlog_a.size();
    run(0, 8'hFE, 8'h20, 8'd3, cyc);
    check("wrap_cycles", cyc, 10);
    check("wrap_rd0", rlog[r0],     8'hFE);
    check("wrap_rd1", rlog[r0 + 1], 8'hFF);
    check("wrap_rd2", rlog[r0 + 2], 8'h00);
    check("wrap_wr0", wlog_a[w0],     8'h20);
    check("wrap_wr2", wlog_a[w0 + 2], 8'h22);
    check("wrap_d0", mem1[8'h20], 8'hA1);
    check("wrap_d2", mem1[8'h22], 8'hC3);

    // Start pulse in the middle of a transfer is ignored
    w0 = wlog_a.size(); nd = 0;
    src = 8'h40; dst = 8'h90; len = 8'd4; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 5);
      if (done1) nd++;
    end
    check("busy_start_writes", wlog_a.size() - w0, 4);
    check("busy_start_done", nd, 1);
    check("busy_start_last", wlog_a[w0 + 3], 8'h93);
    check("busy_start_data", mem1[8'h93], 8'h44);

    // Reset during the WAIT of the second byte
    w0 = wlog_a.size();
    src = 8'h40; dst = 8'hB0; len = 8'd4; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", busy1, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_cs",   r1.Cs, 0);
    check("mid_rst_wen",  r1.Wen, 0);
    check("mid_rst_oen",  r1.Oen, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_writes", wlog_a.size() - w0, 1);
    check("mid_rst_partial", mem1[8'hB0], 8'h11);
    run(0, 8'h41, 8'hC0, 8'd1, cyc);
    check("after_rst_cycles", cyc, 4);
    check("after_rst_data", mem1[8'hC0], 8'h22);

    // Three-cycle read latency
    preload(1, 8'h05, 8'hA5); preload(1, 8'h06, 8'h5A);
    run(1, 8'h05, 8'h60, 8'd2, cyc);
    check("rl3_cycles", cyc, 11);
    check("rl3_b0", mem3[8'h60], 8'hA5);
    check("rl3_b1", mem3[8'h61], 8'h5A);
`ifdef RAM_COPY_MASTER_CHECKSUM_EN
    check("rl3_checksum", csum3, 8'hFF);
`endif

    check("protocol_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
